// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: the fetch unit issues req/addr, memory answers ack/rdata.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch sequencer: fetches one word per instruction over a req/ack
// bus, holds it in IR until the datapath commits, then selects the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_unit_if.master         imem,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                instr,
    output logic [5:0]                 opc,
    output logic [5:0]                 func,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    input  logic                       Branch,
    input  logic                       jump,
    input  logic                       jr,
    input  logic                       zero,
    input  logic [31:0]                jr_target,
    output logic                       addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic        addr_err_reg;
    logic        ir_load;
    logic        commit;
    logic [31:0] br_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'h0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_err_reg <= commit && jr && (jr_target[1:0] != 2'b00);
            if (ir_load) begin
                instr_reg <= imem.imem_rdata;
            end
            if (commit) begin
                pc_reg <= pc_next;
            end
        end
    end

    // Acks outside FETCH and ready outside ISSUE simply fall through the defaults.
    always_comb begin
        state_next = state_reg;
        ir_load    = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (inst_ready) begin
                    commit     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc_plus4  = pc_reg + 32'd4;
    assign br_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};

    // jr beats jump beats taken branch; anything else is sequential.
    always_comb begin
        pc_next = pc_plus4;
        if (jr) begin
            pc_next = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            pc_next = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
        end else if (Branch && zero) begin
            pc_next = pc_plus4 + br_offset;
        end
    end

    assign imem.imem_req  = (state_reg == FETCH);
    assign imem.imem_addr = pc_reg;
    assign inst_valid     = (state_reg == ISSUE);
    assign instr          = instr_reg;
    assign opc            = instr_reg[31:26];
    assign func           = instr_reg[5:0];
    assign pc             = pc_reg;
    assign addr_err       = addr_err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: hand sequences for reset, waits and
// async reset, plus a vector table of control-flow cases with an address scoreboard.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instr;
    logic [5:0]  opc;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        Branch;
    logic        jump;
    logic        jr;
    logic        zero;
    logic [31:0] jr_target;
    logic        addr_err;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .instr      (instr),
        .opc        (opc),
        .func       (func),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .Branch     (Branch),
        .jump       (jump),
        .jr         (jr),
        .zero       (zero),
        .jr_target  (jr_target),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        jmp;
        logic        jr;
        logic        zero;
        logic [31:0] jr_target;
        logic [31:0] exp_next;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        ok = bus.imem_req;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_req: imem_req got 0 expected 1 within 20 cycles");
        end
    endtask

    initial begin
        bit          ok;
        int          reqc;
        logic [31:0] cur;

        // instr, Branch, jump, jr, zero, jr_target, next pc, addr_err
        vecs[0] = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0200, 1'b0};
        vecs[1] = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_01FC, 1'b0};
        vecs[2] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0200, 1'b0};
        vecs[3] = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0204, 1'b0};
        vecs[4] = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h3000_0000, 1'b0};
        vecs[5] = '{32'h0800_0040, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h3000_0100, 1'b0};
        vecs[6] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0456, 32'h0000_0454, 1'b1};
        vecs[7] = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[8] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[9] = '{32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0004, 1'b0};

        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        inst_ready = 1'b0;
        Branch = 1'b0;
        jump = 1'b0;
        jr = 1'b0;
        zero = 1'b0;
        jr_target = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0000_0100);
        chk("rst_instr", instr, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);

        // Sequential: ack and ready tied high, one instruction per two cycles.
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        inst_ready = 1'b1;
        chk("idle_req", {31'b0, bus.imem_req}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("seq%0d_req", k), {31'b0, bus.imem_req}, {31'b0, (k % 2) == 0});
            chk($sformatf("seq%0d_valid", k), {31'b0, inst_valid}, {31'b0, (k % 2) == 1});
            if ((k % 2) == 0)
                chk($sformatf("seq%0d_addr", k), bus.imem_addr, 32'h100 + 32'(4 * (k / 2)));
            if (k == 5)
                bus.imem_ack = 1'b0;
        end

        // Memory wait of 3 cycles, then 2 stall cycles in ISSUE.
        step();
        inst_ready = 1'b0;
        reqc = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.imem_req) reqc++;
            chk($sformatf("wait%0d_addr", c), bus.imem_addr, 32'h0000_010C);
            if (c == 3) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 32'h2402_1234;
            end
            step();
        end
        chk("wait_req_cycles", 32'(reqc), 32'd4);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall%0d_valid", s), {31'b0, inst_valid}, 32'd1);
            chk($sformatf("stall%0d_instr", s), instr, 32'h2402_1234);
            chk($sformatf("stall%0d_pc", s), pc, 32'h0000_010C);
            if (s == 2) inst_ready = 1'b1;
            step();
        end
        bus.imem_ack = 1'b0;
        inst_ready = 1'b0;
        chk("stall_commit_pc", pc, 32'h0000_0110);
        exp_q.push_back(32'h0000_0110);

        // Control-flow vector table, fetch addresses checked against the scoreboard.
        for (int i = 0; i < 10; i++) begin
            wait_req(ok);
            if (!ok) break;
            cur = exp_q.pop_front();
            chk($sformatf("v%0d_fetch_addr", i), bus.imem_addr, cur);
            bus.imem_ack = 1'b1;
            bus.imem_rdata = vecs[i].instr;
            step();
            bus.imem_ack = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, 32'd1);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].instr);
            chk($sformatf("v%0d_opc", i), {26'b0, opc}, {26'b0, vecs[i].instr[31:26]});
            chk($sformatf("v%0d_func", i), {26'b0, func}, {26'b0, vecs[i].instr[5:0]});
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, cur + 32'd4);
            Branch = vecs[i].br;
            jump = vecs[i].jmp;
            jr = vecs[i].jr;
            zero = vecs[i].zero;
            jr_target = vecs[i].jr_target;
            inst_ready = 1'b1;
            step();
            Branch = 1'b0;
            jump = 1'b0;
            jr = 1'b0;
            zero = 1'b0;
            jr_target = 32'h0;
            inst_ready = 1'b0;
            chk($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_next);
            chk($sformatf("v%0d_addr_err", i), {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
            exp_q.push_back(vecs[i].exp_next);
            step();
            chk($sformatf("v%0d_addr_err_end", i), {31'b0, addr_err}, 32'd0);
        end
        chk("jal_link_value", 32'h3000_0000 + 32'd4, 32'h3000_0004);

        // Async reset mid-FETCH, then a late ack during IDLE.
        chk("pre_rst_req", {31'b0, bus.imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("arst_pc", pc, 32'h0000_0100);
        chk("arst_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1111_1111;
        chk("late_ack_idle_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        bus.imem_ack = 1'b0;
        chk("restart_req", {31'b0, bus.imem_req}, 32'd1);
        chk("restart_addr", bus.imem_addr, 32'h0000_0100);
        chk("restart_valid", {31'b0, inst_valid}, 32'd0);
        step();
        chk("late_ack_ignored_req", {31'b0, bus.imem_req}, 32'd1);
        chk("late_ack_ignored_instr", instr, 32'h0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h2222_3333;
        step();
        bus.imem_ack = 1'b0;
        chk("restart_instr", instr, 32'h2222_3333);
        chk("restart_issue_valid", {31'b0, inst_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
